// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit: funct3 encodings,
// FSM state type and small helpers for access width and alignment.
package lsu_pkg;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 encodings share the low codes with the signed loads
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } access_size_e;

    // Width is carried in funct3[1:0]; reserved codes fall back to a word access.
    function automatic access_size_e access_size(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

    // Half-words need an even address, words need a word-aligned address.
    function automatic logic access_misaligned(input logic [2:0] funct3,
                                               input logic [1:0] offset);
        case (access_size(funct3))
            SZ_BYTE: return 1'b0;
            SZ_HALF: return offset[0];
            default: return offset != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: picks the addressed byte/half-word out of the SRAM
// word and sign- or zero-extends it according to funct3.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] dm_do,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection followed by extension; unknown funct3 returns the whole word.
    always_comb begin
        byte_sel = 8'h00;
        half_sel = 16'h0000;
        data     = dm_do;
        case (offset)
            2'd0:    byte_sel = dm_do[7:0];
            2'd1:    byte_sel = dm_do[15:8];
            2'd2:    byte_sel = dm_do[23:16];
            default: byte_sel = dm_do[31:24];
        endcase
        half_sel = offset[1] ? dm_do[31:16] : dm_do[15:0];
        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {24'h000000, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  data = {16'h0000, half_sel};
            default: data = dm_do;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Memory-stage load/store unit. Drives the data SRAM combinationally from the
// EX/MEM inputs, stalls upstream for one cycle on loads to cover the SRAM
// read latency, and registers the aligned result into the MEM/WB stage.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              ex_dm_web,
    input  logic              ex_is_load,
    input  logic [2:0]        ex_funct3,
    input  logic [31:0]       ex_addr,
    input  logic [31:0]       ex_wdata,
    input  logic [4:0]        ex_rd,
    input  logic              ex_wb_en,
    output logic              stall_o,
    output logic              misalign_o,
    output logic              DM_CEB,
    output logic              DM_WEB,
    output logic [ADDR_W-1:0] DM_A,
    output logic [31:0]       DM_DI,
    output logic [31:0]       DM_BWEB,
    input  logic [31:0]       DM_DO,
    output logic              wb_valid,
    output logic              wb_en,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data
);

    lsu_state_e   state_reg;
    logic [2:0]   ld_funct3_reg;
    logic [1:0]   ld_offset_reg;
    logic [4:0]   ld_rd_reg;
    logic         ld_wb_en_reg;

    logic         is_store;
    logic         is_load;
    logic         misaligned;
    logic         can_issue;
    logic         do_store;
    logic         do_load;
    access_size_e size;
    logic [3:0]   lane_en;
    logic [31:0]  lane_bweb;
    logic [31:0]  load_data;

    // Classify the presented instruction; SRAM access only from IDLE and never under reset.
    always_comb begin
        is_store   = ex_valid && !ex_dm_web;
        is_load    = ex_valid && ex_is_load && ex_dm_web;
        size       = access_size(ex_funct3);
        misaligned = (is_store || is_load) && access_misaligned(ex_funct3, ex_addr[1:0]);
        can_issue  = (state_reg == IDLE) && !rst;
        do_store   = can_issue && is_store && !misaligned;
        do_load    = can_issue && is_load && !misaligned;
    end

    // Per-byte-lane write enables; each lane's 8 mask bits are active low.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        assign lane_en[gi] = (size == SZ_WORD)
                          || ((size == SZ_HALF) && (ex_addr[1] == LANE[1]))
                          || ((size == SZ_BYTE) && (ex_addr[1:0] == LANE));
        assign lane_bweb[8*gi +: 8] = {8{~(do_store && lane_en[gi])}};
    end

    // SRAM port and stall; everything parks at its idle value when not accessing.
    always_comb begin
        DM_CEB  = ~(do_store || do_load);
        DM_WEB  = ~do_store;
        DM_A    = (do_store || do_load) ? ex_addr[ADDR_W+1:2] : '0;
        DM_DI   = do_store ? (ex_wdata << {ex_addr[1:0], 3'b000}) : 32'h0;
        DM_BWEB = lane_bweb;
        stall_o = do_load;
    end

    lsu_load_align u_load_align (
        .funct3 (ld_funct3_reg),
        .offset (ld_offset_reg),
        .dm_do  (DM_DO),
        .data   (load_data)
    );

    // FSM and MEM/WB register: results land one edge after presentation, loads one edge later.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            wb_valid      <= 1'b0;
            wb_en         <= 1'b0;
            wb_rd         <= 5'd0;
            wb_data       <= 32'h0;
            misalign_o    <= 1'b0;
            ld_funct3_reg <= 3'd0;
            ld_offset_reg <= 2'd0;
            ld_rd_reg     <= 5'd0;
            ld_wb_en_reg  <= 1'b0;
        end else begin
            misalign_o <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (!ex_valid) begin
                        wb_valid <= 1'b0;
                        wb_en    <= 1'b0;
                    end else if (misaligned) begin
                        // Suppressed access still retires so the pipeline drains cleanly.
                        wb_valid   <= 1'b1;
                        wb_en      <= 1'b0;
                        wb_rd      <= ex_rd;
                        wb_data    <= ex_addr;
                        misalign_o <= 1'b1;
                    end else if (is_load) begin
                        ld_funct3_reg <= ex_funct3;
                        ld_offset_reg <= ex_addr[1:0];
                        ld_rd_reg     <= ex_rd;
                        ld_wb_en_reg  <= ex_wb_en;
                        wb_valid      <= 1'b0;
                        wb_en         <= 1'b0;
                        state_reg     <= LOAD_WAIT;
                    end else if (is_store) begin
                        wb_valid <= 1'b1;
                        wb_en    <= 1'b0;
                        wb_rd    <= ex_rd;
                        wb_data  <= ex_addr;
                    end else begin
                        wb_valid <= 1'b1;
                        wb_en    <= ex_wb_en;
                        wb_rd    <= ex_rd;
                        wb_data  <= ex_addr;
                    end
                end
                LOAD_WAIT: begin
                    // Upstream is still holding the same load; its ex_* inputs are ignored.
                    wb_valid  <= 1'b1;
                    wb_en     <= ld_wb_en_reg;
                    wb_rd     <= ld_rd_reg;
                    wb_data   <= load_data;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/lsu.md
# lsu

Memory-stage load/store unit of the 5-stage RV32I core. It sits directly downstream of the ID/EX control registers and the ALU. It consumes the registered store-enable, funct3, ALU address and rs2 data, and drives the data-memory SRAM port, including the active-low per-bit write mask. Load data is returned aligned and extended into a registered MEM/WB stage. A one-cycle pipeline stall covers the SRAM's synchronous read latency.

## Interface
- ADDR_W, 14, DM word-address width (DM_A); byte address bits [ADDR_W+1:2] are used
- clk  in  1  core clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  EX/MEM slot holds a real instruction
- ex_dm_web  in  1  0 = store, 1 = not a store
- ex_is_load  in  1  instruction is a load
- ex_funct3  in  3  RV32I width/sign field
- ex_addr  in  32  ALU result (memory byte address, or pass-through result)
- ex_wdata  in  32  rs2 store data
- ex_rd  in  5  destination register
- ex_wb_en  in  1  instruction writes rd
- stall_o  out  1  freeze IF/ID/EX and EX/MEM registers this cycle
- misalign_o  out  1  one-cycle pulse: misaligned access suppressed
- DM_CEB  out  1  SRAM chip enable, active low
- DM_WEB  out  1  SRAM write enable, active low
- DM_A  out  ADDR_W  SRAM word address
- DM_DI  out  32  SRAM write data
- DM_BWEB  out  32  SRAM bit write mask, active low (0 = write bit)
- DM_DO  in  32  SRAM read data, valid the cycle after a read is issued
- wb_valid  out  1  MEM/WB slot valid
- wb_en  out  1  write rd
- wb_rd  out  5  destination register
- wb_data  out  32  write-back value

## Operation
- FSM states IDLE and LOAD_WAIT.
- IDLE, ex_valid=0: SRAM idle. At the next edge: wb_valid=0, wb_en=0.
- IDLE, non-memory op (ex_dm_web=1, ex_is_load=0): SRAM idle. At the next edge: wb_valid=1, wb_en=ex_wb_en, wb_rd=ex_rd, wb_data=ex_addr.
- IDLE, store, aligned:
  - DM_CEB=0, DM_WEB=0, DM_A=ex_addr[ADDR_W+1:2], DM_DI=ex_wdata shifted left by 8*ex_addr[1:0].
  - DM_BWEB: SB clears byte lane ex_addr[1:0]; SH clears half-word lane ex_addr[1]; SW clears all bits. All other bits are 1.
  - At the next edge: wb_valid=1, wb_en=0.
- IDLE, load, aligned:
  - DM_CEB=0, DM_WEB=0→1 (read), DM_BWEB=all 1, stall_o=1.
  - Latch funct3, ex_addr[1:0], ex_rd and ex_wb_en. Go to LOAD_WAIT.
- LOAD_WAIT:
  - ex_* inputs are ignored; upstream is still presenting the same load.
  - Extract from DM_DO at the latched offset:
    - LB: sign-extend the byte. LBU: zero-extend the byte.
    - LH: sign-extend the half-word at offset[1]. LHU: zero-extend that half-word.
    - LW: whole word.
    - Reserved funct3: treat as LW.
  - At the edge: wb_valid=1, wb_en=latched wb_en, wb_data=extracted value. Return to IDLE.
  - stall_o=0.
- Misaligned access (SH/LH/LHU with addr[0]=1; SW/LW with addr[1:0]≠0):
  - No SRAM access.
  - At the next edge: misalign_o=1 for one cycle, wb_valid=1, wb_en=0. No stall.
- SRAM outputs when not accessing: DM_CEB=1, DM_WEB=1, DM_BWEB=all 1, DM_A=0, DM_DI=0.

## Timing
- SRAM port outputs and stall_o are combinational from ex_* and state. Everything else is registered.
- Store and non-memory ops: result in wb_* one cycle after presentation (T→T+1).
- Load presented at T:
  - stall_o high during T only.
  - SRAM captures the read at edge T/T+1; DM_DO is valid during T+1.
  - wb_* valid during T+2. The next instruction is presented at T+2.
- Back-to-back loads: a second load is accepted in the first IDLE cycle after LOAD_WAIT. Throughput is one load per 2 cycles.
- Reset (rst=1 at an edge): state=IDLE; wb_valid=0, wb_en=0, wb_rd=0, wb_data=0; misalign_o=0.
  - While rst=1, SRAM outputs are forced idle and stall_o=0.
  - Reset during LOAD_WAIT abandons the load; no write-back occurs.

## Structure
- Shared package lsu_pkg: funct3 constants (LB=000, LH=001, LW=010, LBU=100, LHU=101; SB/SH/SW share 000/001/010) and enum lsu_state_e {IDLE, LOAD_WAIT}.
- Opcode macros remain in define.svh.
- One combinational sub-module, lsu_load_align: inputs funct3, offset[1:0], DM_DO; output 32-bit extended data.

## Test plan
- SB addr=0x0000_0006, rs2=0x0000_00A5 → DM_A=1, DM_DI=0x00A5_0000, DM_BWEB=0xFF00_FFFF, DM_WEB=0. Next cycle wb_en=0.
- LB addr=0x0000_0007, DM_DO=0x8000_0000 → stall_o=1 for one cycle; wb_data=0xFFFF_FF80 two cycles after presentation. LBU at the same address gives 0x0000_0080.
- LH addr=0x0000_0002, DM_DO=0x1234_5678 → wb_data=0x0000_1234. LW addr=0x0000_0010 → DM_A=4, wb_data=0x1234_5678.
- SW addr=0x0000_0002 → DM_CEB stays 1, misalign_o pulses 1, wb_valid=1 with wb_en=0, no stall.
- Non-memory op with ex_addr=0xDEAD_BEEF, ex_rd=5 → next cycle wb_en=1, wb_rd=5, wb_data=0xDEAD_BEEF.
- Load issued, rst=1 during LOAD_WAIT → next cycle state=IDLE, wb_valid=0, no write-back. The following load completes normally.
